// File: rtl/adc_cfg_pkg.sv
// Shared types and default timing for the ADC configuration sequencer.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package adc_cfg_pkg;

    // Width of one ADC configuration word on the SPI link
    localparam int SPI_W = 32;

    // Default link timing, all in usr_clk cycles
    localparam int DEF_CLK_DIV    = 4;
    localparam int DEF_FIFO_DEPTH = 4;
    localparam int DEF_CS_SETUP   = 2;
    localparam int DEF_CS_HOLD    = 2;
    localparam int DEF_GAP        = 4;

    // Sequencer states
    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_SETUP = 3'd1,
        ST_SHIFT = 3'd2,
        ST_HOLD  = 3'd3,
        ST_GAP   = 3'd4
    } seq_state_e;

endpackage

// File: rtl/adc_cfg_sequencer_fifo.sv
// Generic synchronous show-ahead FIFO with occupancy level.
// Latency: a pushed word is visible on pop_dat_o the cycle after the push.
// Backpressure: push is accepted when not full, or when full with a pop in the same cycle; otherwise ignored.
module adc_cfg_sequencer_fifo #(
    parameter int W     = 32,
    parameter int DEPTH = 4
) (
    input  logic                       clk_i,
    input  logic                       rst_ni,
    input  logic                       push_i,
    input  logic [W-1:0]               push_dat_i,
    input  logic                       pop_i,
    output logic [W-1:0]               pop_dat_o,
    output logic                       full_o,
    output logic                       empty_o,
    output logic [$clog2(DEPTH):0]     level_o
);

    localparam int AW = $clog2(DEPTH);
    localparam int LW = AW + 1;

    logic [W-1:0]  mem_q [DEPTH];
    logic [AW-1:0] wr_ptr_q;
    logic [AW-1:0] rd_ptr_q;
    logic [LW-1:0] count_q;
    logic          do_push;
    logic          do_pop;

    assign full_o    = (count_q == LW'(DEPTH));
    assign empty_o   = (count_q == '0);
    assign level_o   = count_q;
    assign pop_dat_o = mem_q[rd_ptr_q];
    assign do_pop    = pop_i && !empty_o;
    assign do_push   = push_i && (!full_o || pop_i);

    // Storage array, written on accepted push only
    always_ff @(posedge clk_i) begin
        if (do_push) begin
            mem_q[wr_ptr_q] <= push_dat_i;
        end
    end

    // Pointers and occupancy; pointers wrap naturally since DEPTH is a power of two
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_push) wr_ptr_q <= wr_ptr_q + AW'(1);
            if (do_pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
            case ({do_push, do_pop})
                2'b10:   count_q <= count_q + LW'(1);
                2'b01:   count_q <= count_q - LW'(1);
                default: count_q <= count_q;
            endcase
        end
    end

endmodule

// File: rtl/adc_cfg_sequencer.sv
// Queues host ADC config words and sends each as one 32-bit SPI mode-0 frame, capturing MISO readback.
// Latency: word strobed into an idle block drives cs_n low two edges later; cs_n low for CS_SETUP+64*CLK_DIV+CS_HOLD cycles.
// Backpressure: none to host; writes arriving with the queue full and no pop are dropped and flagged in ovf_sticky.
module adc_cfg_sequencer
    import adc_cfg_pkg::*;
#(
    parameter int CLK_DIV    = DEF_CLK_DIV,
    parameter int FIFO_DEPTH = DEF_FIFO_DEPTH,
    parameter int CS_SETUP   = DEF_CS_SETUP,
    parameter int CS_HOLD    = DEF_CS_HOLD,
    parameter int GAP        = DEF_GAP
) (
    input  logic                          usr_clk,
    input  logic                          usr_rst_n,
    input  logic                          cfg_wr,
    input  logic [SPI_W-1:0]              cfg_data,
    input  logic                          ovf_clr,
    input  logic                          spi_miso,
    output logic                          spi_sclk,
    output logic                          spi_cs_n,
    output logic                          spi_mosi,
    output logic                          busy,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
    output logic [SPI_W-1:0]              rd_data,
    output logic                          done,
    output logic                          ovf_sticky,
    output logic [15:0]                   words_sent
);

    localparam int CW = 16;
    localparam logic [CW-1:0] SETUP_LAST = CW'(CS_SETUP - 1);
    localparam logic [CW-1:0] DIV_LAST   = CW'(CLK_DIV - 1);
    localparam logic [CW-1:0] HOLD_LAST  = CW'(CS_HOLD - 1);
    localparam logic [CW-1:0] GAP_LAST   = CW'(GAP - 1);
    localparam logic [5:0]    HALF_LAST  = 6'(2 * SPI_W - 1);

    seq_state_e       state_q;
    logic [CW-1:0]    cnt_q;
    logic [5:0]       half_q;
    logic [SPI_W-1:0] tx_q;
    logic [SPI_W-1:0] rx_q;
    logic [SPI_W-1:0] rd_data_q;
    logic             sclk_q;
    logic             cs_n_q;
    logic             done_q;
    logic             ovf_q;
    logic [15:0]      words_q;

    logic             fifo_pop;
    logic             fifo_full;
    logic             fifo_empty;
    logic [SPI_W-1:0] fifo_dout;
    logic             drop;

    // A word is taken from the queue in IDLE, or directly at the end of the GAP so no idle cycle is inserted
    assign fifo_pop = !fifo_empty &&
                      ((state_q == ST_IDLE) || ((state_q == ST_GAP) && (cnt_q == GAP_LAST)));
    assign drop     = cfg_wr && fifo_full && !fifo_pop;

    adc_cfg_sequencer_fifo #(
        .W     (SPI_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk_i      (usr_clk),
        .rst_ni     (usr_rst_n),
        .push_i     (cfg_wr),
        .push_dat_i (cfg_data),
        .pop_i      (fifo_pop),
        .pop_dat_o  (fifo_dout),
        .full_o     (fifo_full),
        .empty_o    (fifo_empty),
        .level_o    (fifo_level)
    );

    // Overflow flag: a drop in the same cycle as a clear keeps the flag set
    always_ff @(posedge usr_clk or negedge usr_rst_n) begin
        if (!usr_rst_n) begin
            ovf_q <= 1'b0;
        end else if (drop) begin
            ovf_q <= 1'b1;
        end else if (ovf_clr) begin
            ovf_q <= 1'b0;
        end
    end

    // Frame sequencer: CS timing, SCLK divider, MOSI shift-out and MISO capture
    always_ff @(posedge usr_clk or negedge usr_rst_n) begin
        if (!usr_rst_n) begin
            state_q   <= ST_IDLE;
            cnt_q     <= '0;
            half_q    <= '0;
            tx_q      <= '0;
            rx_q      <= '0;
            rd_data_q <= '0;
            sclk_q    <= 1'b0;
            cs_n_q    <= 1'b1;
            done_q    <= 1'b0;
            words_q   <= '0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    // start handled below when the queue has a word
                end
                ST_SETUP: begin
                    if (cnt_q == SETUP_LAST) begin
                        // First rising edge: slave has had bit 31 since cs_n fell
                        cnt_q   <= '0;
                        half_q  <= '0;
                        sclk_q  <= 1'b1;
                        rx_q    <= {rx_q[SPI_W-2:0], spi_miso};
                        state_q <= ST_SHIFT;
                    end else begin
                        cnt_q <= cnt_q + CW'(1);
                    end
                end
                ST_SHIFT: begin
                    if (cnt_q == DIV_LAST) begin
                        cnt_q <= '0;
                        if (half_q == HALF_LAST) begin
                            // Low half of the last bit has elapsed; sclk already low
                            state_q <= ST_HOLD;
                        end else begin
                            half_q <= half_q + 6'd1;
                            sclk_q <= ~sclk_q;
                            if (sclk_q) begin
                                tx_q <= {tx_q[SPI_W-2:0], 1'b0};
                            end else begin
                                rx_q <= {rx_q[SPI_W-2:0], spi_miso};
                            end
                        end
                    end else begin
                        cnt_q <= cnt_q + CW'(1);
                    end
                end
                ST_HOLD: begin
                    if (cnt_q == HOLD_LAST) begin
                        cnt_q     <= '0;
                        cs_n_q    <= 1'b1;
                        rd_data_q <= rx_q;
                        done_q    <= 1'b1;
                        words_q   <= words_q + 16'd1;
                        tx_q      <= '0;
                        state_q   <= ST_GAP;
                    end else begin
                        cnt_q <= cnt_q + CW'(1);
                    end
                end
                ST_GAP: begin
                    if (cnt_q == GAP_LAST) begin
                        cnt_q   <= '0;
                        state_q <= ST_IDLE;
                    end else begin
                        cnt_q <= cnt_q + CW'(1);
                    end
                end
                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
            // Frame start overrides IDLE / GAP-end: latch the word, drop cs_n, present bit 31
            if (fifo_pop) begin
                tx_q    <= fifo_dout;
                rx_q    <= '0;
                cs_n_q  <= 1'b0;
                cnt_q   <= '0;
                state_q <= ST_SETUP;
            end
        end
    end

    assign spi_sclk   = sclk_q;
    assign spi_cs_n   = cs_n_q;
    assign spi_mosi   = tx_q[SPI_W-1];
    assign busy       = (state_q != ST_IDLE) || !fifo_empty;
    assign rd_data    = rd_data_q;
    assign done       = done_q;
    assign ovf_sticky = ovf_q;
    assign words_sent = words_q;

endmodule

// File: tb/tb_adc_cfg_sequencer.sv
// Directed bench for adc_cfg_sequencer: frame timing, ordering, overflow, reset abort, readback.
// Latency: n/a.
// Backpressure: n/a.
module tb_adc_cfg_sequencer;

    logic        usr_clk;
    logic        usr_rst_n;
    logic        cfg_wr;
    logic [31:0] cfg_data;
    logic        ovf_clr;
    logic        spi_miso;
    logic        spi_sclk;
    logic        spi_cs_n;
    logic        spi_mosi;
    logic        busy;
    logic [2:0]  fifo_level;
    logic [31:0] rd_data;
    logic        done;
    logic        ovf_sticky;
    logic [15:0] words_sent;

    int n_tests;
    int n_fail;

    // bench-side SPI slave / monitor state
    bit          loop_mode;
    logic [31:0] pattern;
    logic [31:0] pat_sh;
    logic        pat_bit;
    logic        prev_cs;
    logic        prev_sclk;
    int          low_len;
    int          high_len;
    bit          have_prev;
    logic [31:0] cap;
    int          len_q[$];
    logic [31:0] word_q[$];
    int          gap_q[$];
    int          done_cnt;
    int          started;
    int          peak;

    adc_cfg_sequencer dut (
        .usr_clk    (usr_clk),
        .usr_rst_n  (usr_rst_n),
        .cfg_wr     (cfg_wr),
        .cfg_data   (cfg_data),
        .ovf_clr    (ovf_clr),
        .spi_miso   (spi_miso),
        .spi_sclk   (spi_sclk),
        .spi_cs_n   (spi_cs_n),
        .spi_mosi   (spi_mosi),
        .busy       (busy),
        .fifo_level (fifo_level),
        .rd_data    (rd_data),
        .done       (done),
        .ovf_sticky (ovf_sticky),
        .words_sent (words_sent)
    );

    initial usr_clk = 1'b0;
    always #5 usr_clk = ~usr_clk;

    assign spi_miso = loop_mode ? spi_mosi : pat_bit;

    // Monitor on the falling usr_clk edge: frame lengths, gaps, MOSI capture, MISO pattern drive
    always @(negedge usr_clk) begin
        if (!usr_rst_n) begin
            prev_cs = 1'b1; prev_sclk = 1'b0; low_len = 0; high_len = 0; have_prev = 0;
            cap = '0; len_q.delete(); word_q.delete(); gap_q.delete();
            done_cnt = 0; started = 0; peak = 0; pat_bit = 1'b0; pat_sh = '0;
        end else begin
            if (!spi_cs_n) begin
                if (prev_cs) begin
                    if (have_prev) gap_q.push_back(high_len);
                    started++;
                    low_len = 0;
                    cap = '0;
                    pat_sh = pattern;
                    pat_bit = pat_sh[31];
                    pat_sh = {pat_sh[30:0], 1'b0};
                end
                low_len++;
                if (!prev_sclk && spi_sclk) cap = {cap[30:0], spi_mosi};
                if (prev_sclk && !spi_sclk) begin
                    pat_bit = pat_sh[31];
                    pat_sh = {pat_sh[30:0], 1'b0};
                end
            end else begin
                if (!prev_cs) begin
                    len_q.push_back(low_len);
                    word_q.push_back(cap);
                    high_len = 0;
                    have_prev = 1;
                end
                high_len++;
            end
            if (done) done_cnt++;
            if (int'(fifo_level) > peak) peak = int'(fifo_level);
            prev_cs = spi_cs_n;
            prev_sclk = spi_sclk;
        end
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge usr_clk);
        #1;
    endtask

    task automatic apply_reset();
        usr_rst_n = 1'b0;
        cfg_wr = 1'b0;
        ovf_clr = 1'b0;
        repeat (3) tick();
        usr_rst_n = 1'b1;
    endtask

    task automatic strobe(input logic [31:0] d);
        cfg_wr = 1'b1;
        cfg_data = d;
        tick();
        cfg_wr = 1'b0;
    endtask

    task automatic wait_idle(input string tag);
        int n;
        n = 0;
        while (busy && n < 6000) begin
            tick();
            n++;
        end
        chk(tag, 32'(busy), 32'd0);
    endtask

    initial begin
        int n;
        n_tests = 0; n_fail = 0;
        usr_rst_n = 1'b1; cfg_wr = 1'b0; cfg_data = '0; ovf_clr = 1'b0;
        loop_mode = 1'b1; pattern = '0;
        #2 usr_rst_n = 1'b0;
        repeat (2) tick();
        chk("rst_cs_n",  32'(spi_cs_n), 32'd1);
        chk("rst_sclk",  32'(spi_sclk), 32'd0);
        chk("rst_mosi",  32'(spi_mosi), 32'd0);
        chk("rst_busy",  32'(busy), 32'd0);
        chk("rst_level", 32'(fifo_level), 32'd0);
        chk("rst_rd",    rd_data, 32'd0);
        chk("rst_done",  32'(done), 32'd0);
        chk("rst_ovf",   32'(ovf_sticky), 32'd0);
        chk("rst_words", 32'(words_sent), 32'd0);
        tick();
        usr_rst_n = 1'b1;
        tick();

        // single loopback word, including start latency
        strobe(32'hA5C3_0F81);
        chk("t1_k1_cs_n",  32'(spi_cs_n), 32'd1);
        chk("t1_k1_level", 32'(fifo_level), 32'd1);
        chk("t1_k1_busy",  32'(busy), 32'd1);
        tick();
        chk("t1_k2_cs_n",  32'(spi_cs_n), 32'd0);
        chk("t1_k2_level", 32'(fifo_level), 32'd0);
        wait_idle("t1_idle");
        chk("t1_frames",   32'(len_q.size()), 32'd1);
        chk("t1_cs_len",   32'(len_q[0]), 32'd260);
        chk("t1_mosi",     word_q[0], 32'hA5C3_0F81);
        chk("t1_rd",       rd_data, 32'hA5C3_0F81);
        chk("t1_done_cnt", 32'(done_cnt), 32'd1);
        chk("t1_words",    32'(words_sent), 32'd1);
        chk("t1_mosi_idle", 32'(spi_mosi), 32'd0);

        // four back-to-back strobes
        apply_reset();
        for (int i = 1; i <= 4; i++) strobe(32'(i));
        wait_idle("t2_idle");
        chk("t2_frames", 32'(len_q.size()), 32'd4);
        for (int i = 0; i < 4; i++) chk($sformatf("t2_word%0d", i), word_q[i], 32'(i + 1));
        chk("t2_gaps", 32'(gap_q.size()), 32'd3);
        for (int i = 0; i < 3; i++) chk($sformatf("t2_gap%0d", i), 32'(gap_q[i]), 32'd4);
        chk("t2_peak",  32'(peak), 32'd3);
        chk("t2_ovf",   32'(ovf_sticky), 32'd0);
        chk("t2_words", 32'(words_sent), 32'd4);

        // six strobes into a depth-4 queue: sixth dropped, clear vs drop priority
        apply_reset();
        for (int i = 0; i < 6; i++) strobe(32'h10 + 32'(i));
        chk("t3_ovf_set", 32'(ovf_sticky), 32'd1);
        chk("t3_level",   32'(fifo_level), 32'd4);
        cfg_wr = 1'b1; cfg_data = 32'hBAD0_0007; ovf_clr = 1'b1;
        tick();
        cfg_wr = 1'b0;
        chk("t3_clr_vs_drop", 32'(ovf_sticky), 32'd1);
        tick();
        ovf_clr = 1'b0;
        chk("t3_clr_alone", 32'(ovf_sticky), 32'd0);
        wait_idle("t3_idle");
        chk("t3_frames", 32'(len_q.size()), 32'd5);
        for (int i = 0; i < 5; i++) chk($sformatf("t3_word%0d", i), word_q[i], 32'h10 + 32'(i));
        chk("t3_words", 32'(words_sent), 32'd5);

        // push into a full queue on the cycle the GAP end pops
        apply_reset();
        for (int i = 0; i < 5; i++) strobe(32'h20 + 32'(i));
        n = 0;
        while (done !== 1'b1 && n < 2000) begin
            tick();
            n++;
        end
        chk("t4_done_seen", 32'(done), 32'd1);
        repeat (3) tick();
        chk("t4_full_before", 32'(fifo_level), 32'd4);
        chk("t4_cs_high",     32'(spi_cs_n), 32'd1);
        strobe(32'hC0DE_0005);
        chk("t4_ovf",   32'(ovf_sticky), 32'd0);
        chk("t4_level", 32'(fifo_level), 32'd4);
        chk("t4_cs_low", 32'(spi_cs_n), 32'd0);
        wait_idle("t4_idle");
        chk("t4_frames", 32'(len_q.size()), 32'd6);
        chk("t4_last",   word_q[5], 32'hC0DE_0005);
        chk("t4_words",  32'(words_sent), 32'd6);

        // reset in the middle of a frame with two words queued
        apply_reset();
        for (int i = 0; i < 3; i++) strobe(32'h30 + 32'(i));
        repeat (139) tick();
        #2;
        chk("t5_pre_cs_n", 32'(spi_cs_n), 32'd0);
        chk("t5_pre_sclk", 32'(spi_sclk), 32'd1);
        chk("t5_pre_level", 32'(fifo_level), 32'd2);
        usr_rst_n = 1'b0;
        #1;
        chk("t5_cs_n_async", 32'(spi_cs_n), 32'd1);
        chk("t5_sclk_async", 32'(spi_sclk), 32'd0);
        repeat (2) tick();
        usr_rst_n = 1'b1;
        repeat (300) tick();
        chk("t5_no_frame", 32'(started), 32'd0);
        chk("t5_busy",     32'(busy), 32'd0);
        chk("t5_level",    32'(fifo_level), 32'd0);
        chk("t5_words",    32'(words_sent), 32'd0);

        // MISO driven on SCLK falling edges
        apply_reset();
        loop_mode = 1'b0;
        pattern = 32'hDEAD_BEEF;
        strobe(32'h1234_5678);
        wait_idle("t6_idle");
        chk("t6_rd",   rd_data, 32'hDEAD_BEEF);
        chk("t6_mosi", word_q[0], 32'h1234_5678);
        chk("t6_done_cnt", 32'(done_cnt), 32'd1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #600000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

endmodule
